// File: rtl/wired_rr_arbiter.sv
// Round-robin arbiter with hold-until-accepted grants and optional burst lock.
// Define WIRED_RR_ARB_BURST_LOCK_EN to keep a grant across multi-beat transactions.
module wired_rr_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid_i,
    input  logic [N-1:0]    req_last_i,
    output logic [N-1:0]    req_ready_o,
    output logic            gnt_valid_o,
    output logic [IDXW-1:0] gnt_idx_o,
    input  logic            gnt_ready_i,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] sel_q;

    logic [N-1:0]    masked;
    logic [IDXW-1:0] sel;
    logic            xfer;
    logic            final_beat;

    function automatic logic [IDXW-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    // Requests strictly above the pointer win; otherwise wrap to the lowest requester.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req_valid_i[i] && (IDXW'(i) > ptr);
        end
        sel = (|masked) ? lowest_set(masked) : lowest_set(req_valid_i);
    end

    always_comb begin
        if (state == IDLE) begin
            gnt_valid_o = |req_valid_i;
            gnt_idx_o   = sel;
        end else begin
            gnt_valid_o = req_valid_i[sel_q];
            gnt_idx_o   = sel_q;
        end
    end

    assign xfer   = gnt_valid_o && gnt_ready_i;
    assign busy_o = (state != IDLE);

    always_comb begin
        req_ready_o = '0;
        if (xfer) req_ready_o[gnt_idx_o] = 1'b1;
    end

`ifdef WIRED_RR_ARB_BURST_LOCK_EN
    assign final_beat = req_last_i[gnt_idx_o];
`else
    logic unused_last;
    assign unused_last = ^req_last_i;
    assign final_beat  = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= IDXW'(N - 1);
            sel_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (final_beat) begin
                            ptr <= gnt_idx_o;
                        end else begin
                            sel_q <= gnt_idx_o;
                            state <= LOCK;
                        end
                    end else if (gnt_valid_o) begin
                        // Freeze the presented grant until the resource accepts it.
                        sel_q <= gnt_idx_o;
                        state <= HOLD;
                    end
                end
                default: begin
                    if (xfer) begin
                        if (final_beat) begin
                            ptr   <= gnt_idx_o;
                            state <= IDLE;
                        end else begin
                            state <= LOCK;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wired_rr_arbiter.sv
// Directed bench for wired_rr_arbiter (N=4); burst-lock scenarios follow the build macro.
module tb_wired_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [3:0] req_ready;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       gnt_ready;
    logic       busy;

    int passed;
    int total;

    wired_rr_arbiter #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx),
        .gnt_ready_i (gnt_ready),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0; req_last = '0; gnt_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Reset is asserted from time 0.
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt_valid !== 1'b0 || req_ready !== 4'b0000 || gnt_idx !== 2'd0)
            $display("FAIL reset_state busy=%b vld=%b rdy=%b idx=%0d want 0,0,0000,0", busy, gnt_valid, req_ready, gnt_idx);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        // Enter HOLD, then assert reset asynchronously between edges.
        req_valid = 4'b0100; gnt_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || gnt_idx !== 2'd2) $display("FAIL hold_before_reset busy=%b idx=%0d want 1,2", busy, gnt_idx);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL async_reset busy=%b want 0", busy);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_idx [4];
        exp_idx = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'b0101; req_last = 4'b1111; gnt_ready = 1'b1;
            @(negedge clk);
            total++;
            if (gnt_idx !== exp_idx[c] || gnt_valid !== 1'b1 || req_ready !== (4'b0001 << exp_idx[c]))
                $display("FAIL alternate_c%0d idx=%0d rdy=%b want idx=%0d rdy=%b", c, gnt_idx, req_ready, exp_idx[c], 4'b0001 << exp_idx[c]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_all_req();
        logic [3:0] exp_rdy [5];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b1111; req_last = 4'b1111; gnt_ready = 1'b1;
            @(negedge clk);
            total++;
            if (req_ready !== exp_rdy[c] || gnt_idx !== 2'(c % 4))
                $display("FAIL all_req_c%0d rdy=%b idx=%0d want rdy=%b idx=%0d", c, req_ready, gnt_idx, exp_rdy[c], c % 4);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = (c >= 1) ? 4'b0011 : 4'b0010; req_last = 4'b1111; gnt_ready = 1'b0;
            @(negedge clk);
            total++;
            if (gnt_idx !== 2'd1 || gnt_valid !== 1'b1 || req_ready !== 4'b0000 || (c > 0 && busy !== 1'b1))
                $display("FAIL hold_c%0d idx=%0d vld=%b rdy=%b busy=%b want 1,1,0000,%b", c, gnt_idx, gnt_valid, req_ready, busy, c > 0);
            else passed++;
            @(posedge clk); #1;
        end
        gnt_ready = 1'b1;
        @(negedge clk);
        total++;
        if (gnt_idx !== 2'd1 || req_ready !== 4'b0010 || busy !== 1'b1)
            $display("FAIL hold_accept idx=%0d rdy=%b busy=%b want 1,0010,1", gnt_idx, req_ready, busy);
        else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (gnt_idx !== 2'd0 || req_ready !== 4'b0001 || busy !== 1'b0)
            $display("FAIL hold_next idx=%0d rdy=%b busy=%b want 0,0001,0", gnt_idx, req_ready, busy);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        logic [1:0] exp_idx [5];
        int ncyc;
        int left;
`ifdef WIRED_RR_ARB_BURST_LOCK_EN
        exp_idx = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        ncyc = 4;
`else
        exp_idx = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        ncyc = 5;
`endif
        left = 3;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            req_valid = {3'b001, left > 0};
            req_last  = {3'b111, left == 1};
            gnt_ready = 1'b1;
            @(negedge clk);
            total++;
            if (gnt_idx !== exp_idx[c] || req_ready !== (4'b0001 << exp_idx[c]))
                $display("FAIL burst_c%0d idx=%0d rdy=%b want idx=%0d", c, gnt_idx, req_ready, exp_idx[c]);
            else passed++;
            if (req_ready[0]) left--;
            @(posedge clk); #1;
        end
    endtask

`ifdef WIRED_RR_ARB_BURST_LOCK_EN
    task automatic test_reset_lock();
        do_reset();
        req_valid = 4'b0001; req_last = 4'b0001; gnt_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0010; req_last = 4'b0010;
        @(posedge clk); #1;
        req_valid = 4'b1111; req_last = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || gnt_idx !== 2'd2 || req_ready !== 4'b0100)
            $display("FAIL lock_idx2 busy=%b idx=%0d rdy=%b want 1,2,0100", busy, gnt_idx, req_ready);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || gnt_idx !== 2'd0 || req_ready !== 4'b0001)
            $display("FAIL reset_in_lock busy=%b idx=%0d rdy=%b want 0,0,0001", busy, gnt_idx, req_ready);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0; req_last = 4'b1111;
        @(negedge clk);
        total++;
        if (gnt_idx !== 2'd0 || req_ready !== 4'b0001 || busy !== 1'b0)
            $display("FAIL after_lock_reset idx=%0d rdy=%b busy=%b want 0,0001,0", gnt_idx, req_ready, busy);
        else passed++;
        @(posedge clk); #1;
    endtask
`else
    task automatic test_no_lock();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1111; req_last = 4'b0000; gnt_ready = 1'b1;
            @(negedge clk);
            total++;
            if (gnt_idx !== 2'(c) || busy !== 1'b0)
                $display("FAIL no_lock_c%0d idx=%0d busy=%b want %0d,0", c, gnt_idx, busy, c);
            else passed++;
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        passed = 0; total = 0;
        rst = 1'b1;
        req_valid = '0; req_last = '0; gnt_ready = 1'b0;
        test_reset();
        test_alternate();
        test_all_req();
        test_hold();
        test_burst();
`ifdef WIRED_RR_ARB_BURST_LOCK_EN
        test_reset_lock();
`else
        test_no_lock();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
